// File: rtl/dma_write_target.sv
// Posted-write target: incoming master writes are buffered in a FIFO and drained into a
// single-port RAM shared with CPU reads. Optional macro DMA_TARGET_RANGE_CHECK_EN adds err_range.
module dma_write_target #(
   parameter int FIFO_DEPTH   = 8,
   parameter int RAM_WORDS    = 256,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [31:0]                   s_addr,
   input  logic [31:0]                   s_wdata,
   input  logic                          s_we,
   input  logic                          rd_en,
   input  logic [31:0]                   rd_addr,
   output logic                          rd_ready,
   output logic                          rd_valid,
   output logic [31:0]                   rd_data,
   input  logic                          clr_status,
   output logic [31:0]                   wr_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
`ifdef DMA_TARGET_RANGE_CHECK_EN
   output logic                          err_range,
`endif
   output logic                          drain_done
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [AW-1:0]  fifo_idx  [FIFO_DEPTH];
   logic [31:0]    fifo_data [FIFO_DEPTH];
   logic [31:0]    mem       [RAM_WORDS];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [SW-1:0]  starve_cnt;
   logic           empty, full, starved, read_grant, drain;
   logic           in_range, push, drop;
   logic           unused_bits;

`ifdef DMA_TARGET_RANGE_CHECK_EN
   assign in_range    = ({32'd0, s_addr} < (64'(RAM_WORDS) * 64'd4));
   assign unused_bits = ^{s_addr[1:0], rd_addr[31:AW+2], rd_addr[1:0]};
`else
   assign in_range    = 1'b1;
   assign unused_bits = ^{s_addr[31:AW+2], s_addr[1:0], rd_addr[31:AW+2], rd_addr[1:0]};
`endif

   assign empty      = (fifo_level == '0);
   assign full       = (fifo_level == (PW+1)'(FIFO_DEPTH));
   assign starved    = (starve_cnt >= SW'(STARVE_LIMIT));
   assign read_grant = rd_en && !starved;
   assign rd_ready   = rd_en && !(starved && !empty);
   assign drain      = !read_grant && !empty;
   // A pop in the same cycle frees the slot the full-FIFO push lands in.
   assign push       = s_we && in_range && (!full || drain);
   assign drop       = s_we && in_range && full && !drain;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         starve_cnt <= '0;
         wr_count   <= '0;
         overflow   <= 1'b0;
         drain_done <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (drain)
            rd_ptr <= rd_ptr + 1'b1;
         fifo_level <= fifo_level + (PW+1)'(push) - (PW+1)'(drain);
         starve_cnt <= (read_grant && !empty) ? starve_cnt + 1'b1 : '0;
         wr_count   <= clr_status ? {31'd0, drain} : wr_count + {31'd0, drain};
         overflow   <= clr_status ? drop : (overflow | drop);
         drain_done <= drain && (fifo_level == (PW+1)'(1)) && !push;
         rd_valid   <= read_grant;
         if (read_grant)
            rd_data <= mem[rd_addr[AW+1:2]];
      end
   end

`ifdef DMA_TARGET_RANGE_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_range <= 1'b0;
      else
         err_range <= clr_status ? (s_we && !in_range) : (err_range | (s_we && !in_range));
   end
`endif

   // Storage arrays carry no reset; occupancy is tracked by the pointers above.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_idx[wr_ptr]  <= s_addr[AW+1:2];
         fifo_data[wr_ptr] <= s_wdata;
      end
      if (drain)
         mem[fifo_idx[rd_ptr]] <= fifo_data[rd_ptr];
   end

endmodule

// File: tb/tb_dma_write_target.sv
// Self-checking bench for dma_write_target (default build): queue-based reference model
// stepped once per clock, directed scenarios plus a randomized run.
module tb_dma_write_target;
   localparam int FD = 8;
   localparam int RW = 256;
   localparam int SL = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] s_addr = '0, s_wdata = '0, rd_addr = '0;
   logic        s_we = 1'b0, rd_en = 1'b0, clr_status = 1'b0;
   logic        rd_ready, rd_valid, overflow, drain_done;
   logic [31:0] rd_data, wr_count;
   logic [3:0]  fifo_level;

   always #5 clk = ~clk;

   dma_write_target #(.FIFO_DEPTH(FD), .RAM_WORDS(RW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
      .rd_data(rd_data), .clr_status(clr_status), .wr_count(wr_count),
      .fifo_level(fifo_level), .overflow(overflow), .drain_done(drain_done));

   typedef struct { int unsigned idx; logic [31:0] data; } ent_t;
   ent_t        pend[$];
   logic [31:0] shadow [RW];
   bit          known  [RW];
   int          m_starve;
   logic [31:0] m_wrc, m_rdata;
   bit          m_ovf, m_dd, m_rv, m_rknown;
   bit          exp_ready, act_ready, last_full, last_drain;
   int          compared = 0, mismatched = 0;

   task automatic model_reset();
      pend.delete();
      m_starve = 0; m_wrc = '0; m_ovf = 0; m_dd = 0; m_rv = 0;
      m_rdata = '0; m_rknown = 1;
   endtask

   // Entered just after a falling edge with inputs driven; advances model and DUT one clock.
   task automatic tick();
      bit rd, emp, dr, acc, set;
      int nb;
      ent_t e;
      #1;
      nb  = pend.size();
      emp = (nb == 0);
      rd  = rd_en && (m_starve < SL);
      dr  = !rd && !emp;
      exp_ready = rd_en && !((m_starve >= SL) && !emp);
      act_ready = rd_ready;
      last_full = (nb == FD);
      last_drain = dr;
      acc = s_we && (!last_full || dr);
      if (dr) begin
         e = pend.pop_front();
         shadow[e.idx] = e.data;
         known[e.idx]  = 1;
      end
      if (rd) begin
         m_rdata  = shadow[(rd_addr >> 2) % RW];
         m_rknown = known[(rd_addr >> 2) % RW];
      end
      m_rv = rd;
      m_dd = dr && (nb == 1) && !acc;
      if (acc) begin
         e.idx = (s_addr >> 2) % RW;
         e.data = s_wdata;
         pend.push_back(e);
      end
      set   = s_we && !acc;
      m_ovf = clr_status ? set : (m_ovf | set);
      m_wrc = clr_status ? 32'(dr) : m_wrc + 32'(dr);
      m_starve = (rd && !emp) ? m_starve + 1 : 0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1; s_we = 0; rd_en = 0; clr_status = 0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      reset = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      compared++;
      if ({fifo_level, wr_count, overflow, drain_done, rd_valid, rd_data} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs got lvl=%0d wrc=%0d ovf=%b dd=%b rv=%b rdata=%h required all 0",
                  fifo_level, wr_count, overflow, drain_done, rd_valid, rd_data);
      end
      model_reset();
      reset = 0;
   endtask

   task automatic test_burst();
      int dd_seen = 0;
      do_reset();
      rd_en = 0;
      for (int i = 0; i < 8; i++) begin
         s_we = (i < 4); s_addr = 32'(i * 4); s_wdata = 32'hDEADBEEF;
         tick();
         if (drain_done === 1'b1) dd_seen++;
      end
      s_we = 0;
      compared++;
      if (wr_count !== 32'd4) begin
         mismatched++; $display("FAIL burst_wr_count got %0d required 4", wr_count);
      end
      compared++;
      if (dd_seen != 1) begin
         mismatched++; $display("FAIL burst_drain_done_pulses got %0d required 1", dd_seen);
      end
      for (int i = 0; i < 4; i++) begin
         rd_en = 1; rd_addr = 32'(i * 4);
         tick();
         compared++;
         if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL burst_read idx=%0d got rv=%b data=%h required rv=1 data=deadbeef", i, rd_valid, rd_data);
         end
      end
      rd_en = 0;
   endtask

   task automatic test_overflow();
      logic [31:0] base;
      do_reset();
      rd_en = 1; rd_addr = '0;
      for (int i = 0; i < FD + 2; i++) begin
         s_we = 1; s_addr = 32'($urandom_range(16, 63) * 4); s_wdata = $urandom;
         tick();
      end
      s_we = 0; rd_en = 0;
      compared++;
      if (overflow !== 1'b1 || fifo_level !== 4'(FD)) begin
         mismatched++;
         $display("FAIL overflow_flag got ovf=%b lvl=%0d required ovf=1 lvl=%0d", overflow, fifo_level, FD);
      end
      compared++;
      if (wr_count !== m_wrc) begin
         mismatched++; $display("FAIL overflow_wr_count got %0d required %0d", wr_count, m_wrc);
      end
      base = m_wrc;
      for (int i = 0; i < 12; i++) tick();
      compared++;
      if (wr_count - base !== 32'd8 || overflow !== 1'b1) begin
         mismatched++;
         $display("FAIL overflow_commits got %0d ovf=%b required 8 ovf=1", wr_count - base, overflow);
      end
   endtask

   task automatic test_starvation();
      int lows = 0;
      do_reset();
      rd_en = 1; rd_addr = '0;
      for (int i = 0; i < 18; i++) begin
         s_we = (i < 8); s_addr = 32'($urandom_range(16, 63) * 4); s_wdata = $urandom;
         tick();
         compared++;
         if (act_ready !== exp_ready) begin
            mismatched++;
            $display("FAIL starve_rd_ready cyc=%0d got %b required %b", i, act_ready, exp_ready);
         end
         if (i >= 8 && !act_ready) lows++;
      end
      compared++;
      if (lows != 2) begin
         mismatched++; $display("FAIL starve_low_count got %0d required 2 in 10 cycles", lows);
      end
      rd_en = 0; s_we = 0;
   endtask

   task automatic test_full_pop();
      bit hit = 0;
      do_reset();
      rd_en = 1; rd_addr = '0;
      for (int i = 0; i < 60 && !hit; i++) begin
         s_we = (pend.size() < FD) || (m_starve >= SL);
         s_addr = 32'($urandom_range(16, 63) * 4); s_wdata = $urandom;
         tick();
         if (last_full && last_drain && s_we) begin
            hit = 1;
            compared++;
            if (fifo_level !== 4'(FD) || overflow !== 1'b0) begin
               mismatched++;
               $display("FAIL full_pop got lvl=%0d ovf=%b required lvl=%0d ovf=0", fifo_level, overflow, FD);
            end
         end
      end
      if (!hit) begin
         compared++; mismatched++;
         $display("FAIL full_pop_timeout got no full+drain cycle required one within 60 cycles");
      end
      s_we = 0; rd_en = 0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      rd_en = 1; rd_addr = 32'h40;
      for (int i = 0; i < 3; i++) begin
         s_we = 1; s_addr = 32'(i * 4); s_wdata = 32'h12345678;
         tick();
      end
      s_we = 0; rd_en = 0;
      compared++;
      if (fifo_level !== 4'd3) begin
         mismatched++; $display("FAIL mid_pending got lvl=%0d required 3", fifo_level);
      end
      reset = 1;
      #2;
      compared++;
      if (fifo_level !== 4'd0 || wr_count !== 32'd0) begin
         mismatched++;
         $display("FAIL mid_reset got lvl=%0d wrc=%0d required 0 0", fifo_level, wr_count);
      end
      model_reset();
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 4; i++) tick();
      compared++;
      if (wr_count !== 32'd0 || fifo_level !== 4'd0) begin
         mismatched++;
         $display("FAIL mid_no_drain got wrc=%0d lvl=%0d required 0 0", wr_count, fifo_level);
      end
      rd_en = 1; rd_addr = 32'h0;
      tick();
      rd_en = 0;
      compared++;
      if (rd_data !== 32'hDEADBEEF) begin
         mismatched++; $display("FAIL mid_ram_kept got %h required deadbeef", rd_data);
      end
      reset = 1;
      @(negedge clk);
      model_reset();
      reset = 0; s_we = 1; s_addr = 32'h100; s_wdata = 32'hA5A5A5A5;
      tick();
      s_we = 0;
      compared++;
      if (fifo_level !== 4'd1) begin
         mismatched++; $display("FAIL first_push_after_reset got lvl=%0d required 1", fifo_level);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         s_we = ($urandom_range(0, 2) != 0);
         s_addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(16, 63) * 4);
         s_wdata = $urandom;
         rd_en = $urandom_range(0, 1);
         rd_addr = ($urandom & 32'hFFFF_FC03) | 32'($urandom_range(0, 63) * 4);
         clr_status = ($urandom_range(0, 15) == 0);
         tick();
         compared++;
         if (act_ready !== exp_ready) begin
            mismatched++;
            $display("FAIL rand_rd_ready cyc=%0d got %b required %b", i, act_ready, exp_ready);
         end
         compared++;
         if ({fifo_level, wr_count, overflow, drain_done, rd_valid} !==
             {4'(pend.size()), m_wrc, m_ovf, m_dd, m_rv}) begin
            mismatched++;
            $display("FAIL rand_state cyc=%0d got lvl=%0d wrc=%0d ovf=%b dd=%b rv=%b required lvl=%0d wrc=%0d ovf=%b dd=%b rv=%b",
                     i, fifo_level, wr_count, overflow, drain_done, rd_valid,
                     pend.size(), m_wrc, m_ovf, m_dd, m_rv);
         end
         if (m_rknown) begin
            compared++;
            if (rd_data !== m_rdata) begin
               mismatched++;
               $display("FAIL rand_rd_data cyc=%0d got %h required %h", i, rd_data, m_rdata);
            end
         end
      end
      s_we = 0; rd_en = 0; clr_status = 0;
   endtask

   initial begin
      test_reset();
      test_burst();
      test_overflow();
      test_starvation();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got no completion required finish before 1ms");
      $fatal(1, "watchdog");
   end
endmodule
